id_stage: RTL and testbench

- RV32I instruction-decode stage between the fetch stage and the execute stage, with an IF/ID holding register and an ID/EX output register.
- Holds the fetched instruction, drives the register file read addresses and read enables, and generates the immediate and control fields.
- Bypasses a same-cycle writeback, because the register file has no internal write-through.
- Inserts a one-cycle bubble on a load-use hazard and honours ready/valid backpressure and branch flush.

---
 rtl/id_stage.sv | 194 +++++++++++++++++++
 tb/tb_id_stage.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// id_stage: RV32I decode stage sitting between fetch and execute.
// Holds the fetched instruction in D, decodes it, reads/bypasses
// operands and registers the result in E (the ex_* outputs).
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   if_valid/if_ready   - fetch handshake; if_instr, if_pc payload
//   ra1/ra2, re1/re2    - register file read address / enable
//   data1/data2         - register file read data (combinational)
//   wb_we/wb_wa/wb_wdata- writeback port, bypassed into operands
//   flush               - kill D and E contents
//   ex_valid/ex_ready   - execute handshake; ex_* decoded payload
module id_stage #(
    parameter int XLEN      = 32,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_ready,
    output logic [4:0]      ra1,
    output logic [4:0]      ra2,
    output logic            re1,
    output logic            re2,
    input  logic [XLEN-1:0] data1,
    input  logic [XLEN-1:0] data2,
    input  logic            wb_we,
    input  logic [4:0]      wb_wa,
    input  logic [XLEN-1:0] wb_wdata,
    input  logic            flush,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_val,
    output logic [XLEN-1:0] ex_rs2_val,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rd,
    output logic            ex_rd_we,
    output logic [6:0]      ex_opcode,
    output logic [2:0]      ex_funct3,
    output logic            ex_funct7b5,
    output logic            ex_is_load,
    output logic            ex_illegal
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic            d_valid;
    logic [31:0]     d_instr;
    logic [XLEN-1:0] d_pc;

    logic [6:0] opc;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic is_lui, is_auipc, is_jal, is_jalr, is_br;
    logic is_ld, is_st, is_imm, is_reg, is_fence, is_sys;
    logic illegal;
    logic uses_rs1, uses_rs2, writes_rd, rd_we;
    logic byp1, byp2;
    logic stall, e_free, advance;
    logic [XLEN-1:0] imm, op1, op2;

    assign opc = d_instr[6:0];
    assign rs1 = d_instr[19:15];
    assign rs2 = d_instr[24:20];
    assign rd  = d_instr[11:7];

    assign is_lui   = (opc == OP_LUI);
    assign is_auipc = (opc == OP_AUIPC);
    assign is_jal   = (opc == OP_JAL);
    assign is_jalr  = (opc == OP_JALR);
    assign is_br    = (opc == OP_BRANCH);
    assign is_ld    = (opc == OP_LOAD);
    assign is_st    = (opc == OP_STORE);
    assign is_imm   = (opc == OP_IMM);
    assign is_reg   = (opc == OP_REG);
    assign is_fence = (opc == OP_FENCE);
    assign is_sys   = (opc == OP_SYSTEM);

    assign illegal = !(is_lui | is_auipc | is_jal | is_jalr | is_br |
                       is_ld | is_st | is_imm | is_reg | is_fence |
                       is_sys);

    assign uses_rs1  = is_reg | is_imm | is_ld | is_st | is_br | is_jalr;
    assign uses_rs2  = is_reg | is_st | is_br;
    assign writes_rd = !(is_st | is_br);
    assign rd_we     = writes_rd & (rd != 5'd0) & !illegal;

    assign ra1 = rs1;
    assign ra2 = rs2;
    assign re1 = d_valid & uses_rs1;
    assign re2 = d_valid & uses_rs2;

    // The register file has no write-through, so a same-cycle
    // writeback to a source register must be taken from wb_wdata.
    assign byp1 = WB_BYPASS && wb_we && (wb_wa != 5'd0) && (wb_wa == rs1);
    assign byp2 = WB_BYPASS && wb_we && (wb_wa != 5'd0) && (wb_wa == rs2);
    assign op1  = !re1 ? '0 : (byp1 ? wb_wdata : data1);
    assign op2  = !re2 ? '0 : (byp2 ? wb_wdata : data2);

    always_comb begin
        imm = '0;
        unique case (1'b1)
            is_imm, is_ld, is_jalr, is_fence, is_sys:
                imm = {{20{d_instr[31]}}, d_instr[31:20]};
            is_st:
                imm = {{20{d_instr[31]}}, d_instr[31:25], d_instr[11:7]};
            is_br:
                imm = {{19{d_instr[31]}}, d_instr[31], d_instr[7],
                       d_instr[30:25], d_instr[11:8], 1'b0};
            is_lui, is_auipc:
                imm = {d_instr[31:12], 12'b0};
            is_jal:
                imm = {{11{d_instr[31]}}, d_instr[31], d_instr[19:12],
                       d_instr[20], d_instr[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

    // A load in E cannot forward its data yet; hold the consumer in D
    // for one cycle until the load has left E.
    assign stall = d_valid & ex_valid & ex_is_load & (ex_rd != 5'd0) &
                   ((uses_rs1 & (rs1 == ex_rd)) |
                    (uses_rs2 & (rs2 == ex_rd)));

    assign e_free   = !ex_valid | ex_ready;
    assign advance  = d_valid & !stall & e_free;
    assign if_ready = !d_valid | advance;

    always_ff @(posedge clk) begin
        if (reset) begin
            d_valid <= 1'b0;
            d_instr <= '0;
            d_pc    <= '0;
        end else if (flush) begin
            d_valid <= 1'b0;
        end else if (if_valid && if_ready) begin
            d_valid <= 1'b1;
            d_instr <= if_instr;
            d_pc    <= if_pc;
        end else if (advance) begin
            d_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_val  <= '0;
            ex_rs2_val  <= '0;
            ex_imm      <= '0;
            ex_rd       <= '0;
            ex_rd_we    <= 1'b0;
            ex_opcode   <= '0;
            ex_funct3   <= '0;
            ex_funct7b5 <= 1'b0;
            ex_is_load  <= 1'b0;
            ex_illegal  <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (advance) begin
            ex_valid    <= 1'b1;
            ex_pc       <= d_pc;
            ex_rs1_val  <= op1;
            ex_rs2_val  <= op2;
            ex_imm      <= imm;
            ex_rd       <= rd;
            ex_rd_we    <= rd_we;
            ex_opcode   <= opc;
            ex_funct3   <= d_instr[14:12];
            ex_funct7b5 <= d_instr[30];
            ex_is_load  <= is_ld;
            ex_illegal  <= illegal;
        end else if (e_free) begin
            // Bubble: payload fields keep their old value.
            ex_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed stimulus for id_stage with an in-order
// transaction scoreboard and literal spot checks.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic [4:0]  ra1, ra2;
    logic        re1, re2;
    logic [31:0] data1, data2;
    logic        wb_we;
    logic [4:0]  wb_wa;
    logic [31:0] wb_wdata;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
    logic [4:0]  ex_rd;
    logic        ex_rd_we;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic        ex_funct7b5, ex_is_load, ex_illegal;

    always #5 clk = ~clk;

    logic [31:0] rf [32];
    assign data1 = rf[ra1];
    assign data2 = rf[ra2];

    id_stage #(.XLEN(32), .WB_BYPASS(1'b1)) dut (
        .clk(clk), .reset(reset),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .if_ready(if_ready),
        .ra1(ra1), .ra2(ra2), .re1(re1), .re2(re2),
        .data1(data1), .data2(data2),
        .wb_we(wb_we), .wb_wa(wb_wa), .wb_wdata(wb_wdata),
        .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
        .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_rd_we(ex_rd_we),
        .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
        .ex_funct7b5(ex_funct7b5), .ex_is_load(ex_is_load),
        .ex_illegal(ex_illegal)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1v;
        logic [31:0] rs2v;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        rd_we;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        ld;
        logic        ill;
    } exp_t;

    int   passed = 0;
    int   total = 0;
    int   consumed = 0;
    exp_t q[$];

    task automatic check(input string name, input logic [159:0] act,
                         input logic [159:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] opv(input logic [4:0] r, input logic u);
        if (!u) return 32'd0;
        if (wb_we && wb_wa != 5'd0 && wb_wa == r) return wb_wdata;
        return rf[r];
    endfunction

    // What the decoded bundle must be, from the ISA field rules.
    function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc);
        exp_t e;
        logic u1, u2, wr, ill;
        logic [31:0] imm, sgn;
        sgn = 32'($signed(i) >>> 31);
        u1 = 0; u2 = 0; wr = 1; ill = 0; imm = 0;
        case (i[6:0])
            7'h33: begin u1 = 1; u2 = 1; end
            7'h13, 7'h03, 7'h67: begin
                u1 = 1; imm = 32'($signed(i) >>> 20);
            end
            7'h0F, 7'h73: imm = 32'($signed(i) >>> 20);
            7'h23: begin
                u1 = 1; u2 = 1; wr = 0;
                imm = (32'($signed(i) >>> 25) << 5) | 32'(i[11:7]);
            end
            7'h63: begin
                u1 = 1; u2 = 1; wr = 0;
                imm = (sgn << 12) | (32'(i[7]) << 11) |
                      (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
            end
            7'h37, 7'h17: imm = i & 32'hFFFF_F000;
            7'h6F: imm = (sgn << 20) | (32'(i[19:12]) << 12) |
                         (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
            default: begin ill = 1; wr = 0; end
        endcase
        e.pc = pc;
        e.rs1v = opv(i[19:15], u1);
        e.rs2v = opv(i[24:20], u2);
        e.imm = imm;
        e.rd = i[11:7];
        e.rd_we = wr && (i[11:7] != 5'd0);
        e.op = i[6:0];
        e.f3 = i[14:12];
        e.f7 = i[30];
        e.ld = (i[6:0] == 7'h03);
        e.ill = ill;
        return e;
    endfunction

    exp_t prev;
    logic prev_hold = 1'b0;

    always @(negedge clk) begin
        exp_t act, e;
        act = {ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_rd, ex_rd_we,
               ex_opcode, ex_funct3, ex_funct7b5, ex_is_load, ex_illegal};
        if (prev_hold) check("held E", {ex_valid, act}, {1'b1, prev});
        prev_hold = ex_valid && !ex_ready && !reset && !flush;
        prev = act;
        if (ex_valid && ex_ready && !reset) begin
            if (q.size() == 0) begin
                check("spurious ex_valid", 160'(ex_valid), 160'd0);
            end else begin
                e = q.pop_front();
                check("ex bundle vs model", act, e);
                consumed++;
            end
        end
        if (reset || flush) q.delete();
        else if (if_valid && if_ready) q.push_back(model(if_instr, if_pc));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] i, input logic [31:0] p);
        int n = 0;
        if_valid = 1'b1;
        if_instr = i;
        if_pc = p;
        do begin
            @(negedge clk);
            n++;
        end while (!if_ready && n < 20);
        if (!if_ready) check("accept timeout", 160'(if_ready), 160'd1);
        step();
        if_valid = 1'b0;
    endtask

    task automatic wait_ex(input logic [31:0] pc);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(ex_valid && ex_pc == pc) && n < 20);
        if (!(ex_valid && ex_pc == pc))
            check("ex timeout", 160'(ex_pc), 160'(pc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 32; k++) rf[k] = (k == 0) ? 32'd0 : 32'hA000_0000 + k;
        reset = 1; if_valid = 0; if_instr = 0; if_pc = 0;
        wb_we = 0; wb_wa = 0; wb_wdata = 0; flush = 0; ex_ready = 1;
        repeat (2) @(negedge clk);
        check("rst ex_valid", 160'(ex_valid), 160'd0);
        check("rst if_ready", 160'(if_ready), 160'd1);
        check("rst ex_pc", 160'(ex_pc), 160'd0);
        check("rst ex_imm", 160'(ex_imm), 160'd0);
        check("rst re1", 160'(re1), 160'd0);
        step();
        reset = 0;

        // 1: addi x1,x0,5
        send(32'h0050_0093, 32'h100);
        @(negedge clk);
        check("t1 re1", 160'(re1), 160'd1);
        check("t1 re2", 160'(re2), 160'd0);
        @(negedge clk);
        check("t1 ex_valid", 160'(ex_valid), 160'd1);
        check("t1 ex_pc", 160'(ex_pc), 160'h100);
        check("t1 ex_imm", 160'(ex_imm), 160'd5);
        check("t1 ex_rd", 160'(ex_rd), 160'd1);
        check("t1 ex_rd_we", 160'(ex_rd_we), 160'd1);
        check("t1 ex_rs1_val", 160'(ex_rs1_val), 160'd0);

        // 2: writeback bypass into add x2,x1,x1
        step();
        rf[1] = 0; wb_we = 1; wb_wa = 1; wb_wdata = 32'h1234;
        send(32'h0010_8133, 32'h104);
        wait_ex(32'h104);
        check("t2 byp rs1", 160'(ex_rs1_val), 160'h1234);
        check("t2 byp rs2", 160'(ex_rs2_val), 160'h1234);
        step();
        wb_wa = 0; wb_wdata = 32'hFFFF;
        send(32'h0010_8133, 32'h108);
        wait_ex(32'h108);
        check("t2 x0 rs1", 160'(ex_rs1_val), 160'd0);
        check("t2 x0 rs2", 160'(ex_rs2_val), 160'd0);
        step();
        wb_we = 0; rf[1] = 32'hA000_0001;

        // 3: lw x2,0(x1) ; add x3,x2,x1
        send(32'h0000_A103, 32'h200);
        send(32'h0011_01B3, 32'h204);
        @(negedge clk);
        check("t3 lw in E", 160'(ex_pc), 160'h200);
        check("t3 is_load", 160'(ex_is_load), 160'd1);
        check("t3 stall if_ready", 160'(if_ready), 160'd0);
        @(negedge clk);
        check("t3 bubble", 160'(ex_valid), 160'd0);
        check("t3 if_ready after", 160'(if_ready), 160'd1);
        @(negedge clk);
        check("t3 add valid", 160'(ex_valid), 160'd1);
        check("t3 add pc", 160'(ex_pc), 160'h204);
        check("t3 add rs1", 160'(ex_rs1_val), 160'hA000_0002);

        // 4: backpressure with D and E full
        step();
        ex_ready = 0;
        send(32'h0070_0293, 32'h300);
        send(32'h0080_0313, 32'h304);
        if_valid = 1; if_instr = 32'h0062_83B3; if_pc = 32'h308;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t4 hold valid", 160'(ex_valid), 160'd1);
            check("t4 hold pc", 160'(ex_pc), 160'h300);
            check("t4 if_ready", 160'(if_ready), 160'd0);
        end
        step();
        ex_ready = 1;
        send(32'h0062_83B3, 32'h308);
        wait_ex(32'h308);
        check("t4 add rs1", 160'(ex_rs1_val), 160'hA000_0005);

        // 5: immediates and destination rules
        step();
        send(32'hFE00_0EE3, 32'h400);
        wait_ex(32'h400);
        check("t5 B imm", 160'(ex_imm), 160'hFFFF_FFFC);
        step();
        send(32'h1234_50B7, 32'h404);
        wait_ex(32'h404);
        check("t5 U imm", 160'(ex_imm), 160'h1234_5000);
        step();
        send(32'h0000_0023, 32'h408);
        wait_ex(32'h408);
        check("t5 sb rd_we", 160'(ex_rd_we), 160'd0);
        step();
        send(32'h0000_007F, 32'h40C);
        wait_ex(32'h40C);
        check("t5 illegal", 160'(ex_illegal), 160'd1);
        check("t5 ill rd_we", 160'(ex_rd_we), 160'd0);
        step();
        send(32'h0080_00EF, 32'h410);
        wait_ex(32'h410);
        check("t5 J imm", 160'(ex_imm), 160'd8);
        step();
        send(32'h0020_A223, 32'h414);
        wait_ex(32'h414);
        check("t5 S imm", 160'(ex_imm), 160'd4);
        check("t5 sw rs2", 160'(ex_rs2_val), 160'hA000_0002);

        // 6: flush with an offered instruction
        step();
        ex_ready = 0;
        send(32'h0070_0293, 32'h500);
        send(32'h0080_0313, 32'h504);
        ex_ready = 1; flush = 1;
        if_valid = 1; if_instr = 32'h0062_83B3; if_pc = 32'h508;
        @(negedge clk);
        check("t6 if_ready", 160'(if_ready), 160'd1);
        step();
        flush = 0; if_valid = 0;
        @(negedge clk);
        check("t6 ex_valid", 160'(ex_valid), 160'd0);
        check("t6 d empty", 160'(if_ready), 160'd1);
        check("t6 re1", 160'(re1), 160'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t6 no ghost", 160'(ex_valid), 160'd0);
        end

        // reset during a load-use stall
        step();
        send(32'h0000_A103, 32'h600);
        send(32'h0011_01B3, 32'h604);
        reset = 1;
        @(negedge clk);
        @(negedge clk);
        check("t6 rst ex_valid", 160'(ex_valid), 160'd0);
        check("t6 rst if_ready", 160'(if_ready), 160'd1);
        check("t6 rst ex_pc", 160'(ex_pc), 160'd0);
        check("t6 rst ex_rs1", 160'(ex_rs1_val), 160'd0);
        check("t6 rst ex_rd", 160'(ex_rd), 160'd0);
        check("t6 rst is_load", 160'(ex_is_load), 160'd0);
        check("t6 rst re1", 160'(re1), 160'd0);
        step();
        reset = 0;
        repeat (3) @(negedge clk);

        check("queue drained", 160'(q.size()), 160'd0);
        check("consumed count", 160'(consumed), 160'd15);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
